// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        QUEUED = 2'd1,
        FORCE  = 2'd2
    } wb_arb_state_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_req_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_result_fifo.sv
// MDU result buffer: DEPTH-entry circular FIFO, head visible combinationally.
// Latency: push visible at head one edge later. Backpressure: push ignored when full, pop ignored when empty.
// Pointers wrap by power-of-two masking.
module wb_result_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  wb_req_t                    push_req,
    input  logic                       pop,
    output wb_req_t                    head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] MASK = AW'(DEPTH - 1);

    wb_req_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_req;
                wr_ptr      <= (wr_ptr + AW'(1)) & MASK;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr + AW'(1)) & MASK;
            end
            if (do_push && !do_pop) begin
                count <= count + (AW + 1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback (priority) and buffered MDU results.
// Latency: granted write on rf_* one edge after grant; MDU min 2 edges (1 with WB_ARB_MDU_BYPASS_EN).
// Backpressure: mdu_ready drops when FIFO full; pipe_stall holds the pipeline while a starved head is forced.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    output logic        pipe_stall,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    output logic        rf_wr_enable,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wr_data,
    output logic        mdu_pending
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam int NW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    wb_arb_state_t state;
    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] cnt_next;
    wb_req_t       head;
    wb_req_t       win;
    logic          fifo_full;
    logic          fifo_empty;
    logic [NW-1:0] fifo_cnt;
    logic          grant_pipe;
    logic          grant_fifo;
    logic          grant_byp;
    logic          push;
    logic          empty_next;

    always_comb begin
        grant_pipe = 1'b0;
        grant_fifo = 1'b0;
        grant_byp  = 1'b0;
        pipe_stall = 1'b0;
        if (state == FORCE) begin
            grant_fifo = 1'b1;
            pipe_stall = pipe_valid;
        end else if (pipe_valid) begin
            grant_pipe = 1'b1;
        end else if (!fifo_empty) begin
            grant_fifo = 1'b1;
`ifdef WB_ARB_MDU_BYPASS_EN
        end else if (state == IDLE && mdu_valid) begin
            grant_byp = 1'b1;
`endif
        end
    end

    assign mdu_ready   = !fifo_full && !rst;
    assign mdu_pending = !fifo_empty;
    assign push        = mdu_valid && mdu_ready && !grant_byp;

    always_comb begin
        win = '{rd: mdu_rd, data: mdu_data};
        if (grant_pipe) begin
            win = '{rd: pipe_rd, data: pipe_data};
        end else if (grant_fifo) begin
            win = head;
        end
    end

    // Only cycles where a buffered result is actually passed over count as starvation.
    always_comb begin
        cnt_next = starve_cnt;
        if (grant_fifo) begin
            cnt_next = '0;
        end else if (grant_pipe && !fifo_empty && starve_cnt != LIMIT) begin
            cnt_next = starve_cnt + CW'(1);
        end
    end

    assign empty_next = !push && (fifo_empty || (grant_fifo && fifo_cnt == NW'(1)));

    wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_req ('{rd: mdu_rd, data: mdu_data}),
        .pop      (grant_fifo),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            starve_cnt   <= '0;
            rf_wr_enable <= 1'b0;
            rf_rd        <= '0;
            rf_wr_data   <= '0;
        end else begin
            starve_cnt <= cnt_next;
            unique case (state)
                IDLE:    state <= empty_next ? IDLE : QUEUED;
                QUEUED:  state <= empty_next ? IDLE : ((cnt_next == LIMIT) ? FORCE : QUEUED);
                FORCE:   state <= empty_next ? IDLE : QUEUED;
                default: state <= IDLE;
            endcase
            // x0 writes still consume the grant but never reach the register file.
            rf_wr_enable <= (grant_pipe || grant_fifo || grant_byp) && (win.rd != REG_ZERO);
            if ((grant_pipe || grant_fifo || grant_byp) && (win.rd != REG_ZERO)) begin
                rf_rd      <= win.rd;
                rf_wr_data <= win.data;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed bench for wb_port_arbiter with a queue-based reference model and write scoreboard.
module tb_wb_port_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_valid = 1'b0;
    logic [4:0]  pipe_rd = '0;
    logic [31:0] pipe_data = '0;
    logic        pipe_stall;
    logic        mdu_valid = 1'b0;
    logic        mdu_ready;
    logic [4:0]  mdu_rd = '0;
    logic [31:0] mdu_data = '0;
    logic        rf_wr_enable;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wr_data;
    logic        mdu_pending;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_valid   (pipe_valid),
        .pipe_rd      (pipe_rd),
        .pipe_data    (pipe_data),
        .pipe_stall   (pipe_stall),
        .mdu_valid    (mdu_valid),
        .mdu_ready    (mdu_ready),
        .mdu_rd       (mdu_rd),
        .mdu_data     (mdu_data),
        .rf_wr_enable (rf_wr_enable),
        .rf_rd        (rf_rd),
        .rf_wr_data   (rf_wr_data),
        .mdu_pending  (mdu_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } req_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          at;
    } exp_t;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    req_t mq[$];
    exp_t sb[$];
    int   head_wait = 0;
    bit   force_m = 1'b0;
    bit   p_pend = 1'b0;
    bit   m_pend = 1'b0;
    bit   chk_rst = 1'b0;
    req_t p_req = '{5'd0, 32'd0};
    req_t m_req = '{5'd0, 32'd0};

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every observed register-file write must be the next expected one, on time.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0 && sb[0].at < cyc) begin
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL missing_write: rd=%0d data=%0h never appeared at cycle %0d", e.rd, e.data, e.at);
        end
        if (rf_wr_enable === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_write: got rd=%0d data=%0h expected no write (cycle %0d)", rf_rd, rf_wr_data, cyc);
            end else begin
                e = sb.pop_front();
                chk("wr_rd", 64'(rf_rd), 64'(e.rd));
                chk("wr_data", 64'(rf_wr_data), 64'(e.data));
                chk("wr_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    // One clock of stimulus plus model evaluation; new requests are taken only when the previous one was accepted.
    task automatic step(input bit r, input bit np, input logic [4:0] prd, input logic [31:0] pd,
                        input bit nm, input logic [4:0] mrd, input logic [31:0] md);
        bit   gp, gf, gb, stall_e, ready_e, pend_e;
        req_t w;
        w = '{5'd0, 32'd0};
        if (np && !p_pend) begin p_pend = 1'b1; p_req = '{prd, pd}; end
        if (nm && !m_pend) begin m_pend = 1'b1; m_req = '{mrd, md}; end
        rst        = r;
        pipe_valid = p_pend && !r;
        pipe_rd    = p_req.rd;
        pipe_data  = p_req.data;
        mdu_valid  = m_pend && !r;
        mdu_rd     = m_req.rd;
        mdu_data   = m_req.data;
        #3;
        if (chk_rst) begin
            chk("reset_rf_en", 64'(rf_wr_enable), 64'd0);
            chk("reset_rf_rd", 64'(rf_rd), 64'd0);
            chk("reset_rf_data", 64'(rf_wr_data), 64'd0);
            chk("reset_pending", 64'(mdu_pending), 64'd0);
            chk_rst = 1'b0;
        end
        if (r) begin
            chk("ready_in_reset", 64'(mdu_ready), 64'd0);
            mq.delete();
            head_wait = 0;
            force_m   = 1'b0;
            chk_rst   = 1'b1;
        end else begin
            ready_e = (mq.size() < DEPTH);
            pend_e  = (mq.size() != 0);
            gp = 1'b0; gf = 1'b0; gb = 1'b0; stall_e = 1'b0;
            if (force_m) begin
                gf = 1'b1;
                stall_e = pipe_valid;
            end else if (pipe_valid) begin
                gp = 1'b1;
            end else if (mq.size() != 0) begin
                gf = 1'b1;
`ifdef WB_ARB_MDU_BYPASS_EN
            end else if (mdu_valid) begin
                gb = 1'b1;
`endif
            end
            chk("pipe_stall", 64'(pipe_stall), 64'(stall_e));
            chk("mdu_ready", 64'(mdu_ready), 64'(ready_e));
            chk("mdu_pending", 64'(mdu_pending), 64'(pend_e));
            if (gp) begin
                w = p_req;
                p_pend = 1'b0;
                if (mq.size() != 0 && head_wait < LIMIT) head_wait++;
            end else if (gf) begin
                w = mq.pop_front();
                head_wait = 0;
            end else if (gb) begin
                w = m_req;
                m_pend = 1'b0;
            end
            if (mdu_valid && ready_e && !gb) begin
                mq.push_back(m_req);
                m_pend = 1'b0;
            end
            force_m = (head_wait == LIMIT);
            if ((gp || gf || gb) && w.rd != 5'd0) sb.push_back('{w.rd, w.data, cyc + 1});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        int pbias, mbias;
        #1;
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // pipeline only
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        idle(2);

        // idle drain
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12345678);
        idle(3);

        // starvation under continuous pipeline traffic
        step(1'b0, 1'b1, 5'd1, 32'h0000_1111, 1'b1, 5'd3, 32'h00C0FFEE);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 5'(8 + i), 32'hA000_0000 + 32'(i), 1'b0, 5'd0, 32'd0);
        idle(3);

        // full FIFO: third result must be held
        for (int i = 0; i < 14; i++)
            step(1'b0, 1'b1, 5'(16 + i), 32'hB000_0000 + 32'(i), i < 3, 5'(20 + i), 32'hC000_0000 + 32'(i));
        idle(8);

        // x0 discard
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
        idle(3);

        // reset mid-operation with two buffered entries
        step(1'b0, 1'b1, 5'd11, 32'h1111_0000, 1'b1, 5'd9, 32'h9999_0000);
        step(1'b0, 1'b1, 5'd12, 32'h2222_0000, 1'b1, 5'd10, 32'hAAAA_0000);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        idle(4);

        // randomized phases with varying pipeline pressure
        for (int ph = 0; ph < 6; ph++) begin
            pbias = (ph % 3 == 0) ? 95 : ((ph % 3 == 1) ? 55 : 20);
            mbias = (ph < 3) ? 60 : 30;
            for (int i = 0; i < 500; i++) begin
                step($urandom_range(0, 249) == 0,
                     $urandom_range(0, 99) < pbias, 5'($urandom_range(0, 31)), 32'($urandom),
                     $urandom_range(0, 99) < mbias, 5'($urandom_range(0, 31)), 32'($urandom));
            end
        end
        idle(20);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        chk("model_fifo_drained", 64'(mq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline writeback stage and the multi-cycle multiply/divide unit (MDU). The pipeline has priority; MDU results are buffered in a small FIFO and drained into idle write slots. A starvation counter forces an MDU drain and stalls the pipeline writeback when buffered results wait too long. Sits between `stage_writeback`, the MDU result port and the register file.

## Interface
- `DEPTH`, 2: MDU result FIFO entries. Power of two, at least 2.
- `STARVE_LIMIT`, 4: consecutive denied cycles before the FIFO head is forced. At least 1.
- `clk`  in  1  clock.
- `rst`  in  1  reset. Synchronous, active-high; all registers reset on the `clk` edge where `rst`=1.
- `pipe_valid`  in  1  pipeline write request (writeback `wb_regfile_wr_enable`).
- `pipe_rd`  in  5  pipeline destination register.
- `pipe_data`  in  32  pipeline write data.
- `pipe_stall`  out  1  pipeline write not accepted this cycle; `pipe_*` must be held stable.
- `mdu_valid`  in  1  MDU result valid.
- `mdu_ready`  out  1  FIFO can accept; transfer occurs when `mdu_valid` and `mdu_ready` are both 1.
- `mdu_rd`  in  5  MDU destination register.
- `mdu_data`  in  32  MDU result.
- `rf_wr_enable`  out  1  register-file write enable, registered.
- `rf_rd`  out  5  register-file write address, registered.
- `rf_wr_data`  out  32  register-file write data, registered.
- `mdu_pending`  out  1  FIFO non-empty; hazard unit uses it to hold dependent issue.

## Operation
- States: IDLE (FIFO empty), QUEUED (FIFO non-empty, pipeline priority), FORCE (FIFO head owns port).
- IDLE to QUEUED on push. QUEUED to IDLE on pop when count becomes 0.
- QUEUED to FORCE when the starve counter reaches STARVE_LIMIT. FORCE always pops the head next cycle, then goes to QUEUED or IDLE and clears the counter.
- Grant in IDLE/QUEUED:
  - `pipe_valid`=1: pipeline wins.
  - otherwise FIFO head wins if the FIFO is non-empty.
- Grant in FORCE: FIFO head wins and `pipe_stall`=`pipe_valid`.
- Starve counter:
  - increments each cycle the FIFO is non-empty and the pipeline wins;
  - clears on any pop;
  - saturates at STARVE_LIMIT.
- `rd`=0 writes: the grant is consumed and a FIFO entry is still popped, but `rf_wr_enable` stays 0.
- Push and pop in the same cycle: allowed, count unchanged.
- `mdu_ready` = not full and not `rst`. A full FIFO with a simultaneous pop still reports `mdu_ready`=0 (no full-pass-through).
- Reset values: FIFO empty, counter 0, IDLE, `rf_wr_enable`=0, `rf_rd`=0, `rf_wr_data`=0, `mdu_pending`=0. Reset mid-drain discards buffered results.

## Timing
- `pipe_stall`, `mdu_ready` and `mdu_pending` are combinational from state and inputs.
- Granted write appears on `rf_*` one edge after the grant cycle.
- Pipeline path latency: 1 cycle, matching a registered writeback.
- MDU path minimum latency: push at edge N, grant in cycle N+1, `rf_*` valid after edge N+2. With bypass, 1 cycle (see Configuration).
- Worst-case MDU wait under continuous `pipe_valid`: STARVE_LIMIT+1 cycles from reaching the FIFO head.
- A stalled pipeline write is granted in the cycle after FORCE.

## Configuration
- `WB_ARB_MDU_BYPASS_EN` defined: in IDLE with `pipe_valid`=0 and `mdu_valid`=1, the MDU result is granted directly without entering the FIFO.
  - `rf_*` valid one edge later.
  - `mdu_pending` stays 0 for that result.
- Not defined: every MDU result passes through the FIFO.

## Structure
- Package `wb_arb_pkg`:
  - state enum `wb_arb_state_t` {IDLE, QUEUED, FORCE};
  - `wb_req_t` struct {rd[4:0], data[31:0]};
  - constant `REG_ZERO`=5'd0.
- Sub-module `wb_result_fifo`:
  - parameterised DEPTH, synchronous `rst`;
  - push/pop, full/empty, head output;
  - pointer wrap via power-of-two masking.
- The arbiter FSM, starve counter and output registers live in `wb_port_arbiter`.

## Test plan
- Pipeline only: `pipe_valid`=1, rd=5, data=0xDEADBEEF, `mdu_valid`=0 -> next cycle `rf_wr_enable`=1, `rf_rd`=5, `rf_wr_data`=0xDEADBEEF; `pipe_stall`=0.
- Idle drain: one MDU push rd=7, data=0x12345678, `pipe_valid`=0 thereafter -> `rf_*`=7/0x12345678 two cycles after push (one cycle with bypass macro); `mdu_pending` then 0.
- Starvation: FIFO holds rd=3, `pipe_valid`=1 continuously, STARVE_LIMIT=4 -> four pipeline writes, then `pipe_stall`=1 for one cycle, rd=3 written, then the held pipeline write lands.
- Full: DEPTH=2, two pushes under continuous `pipe_valid` -> `mdu_ready`=0; third `mdu_valid` is held, accepted the cycle after the first pop.
- x0 discard: MDU rd=0 data=0xFFFFFFFF -> entry popped, `rf_wr_enable` stays 0, `mdu_pending` returns to 0.
- Reset mid-operation: FIFO holds 2 entries, `rst`=1 for one edge -> all outputs at reset values, no stale writes afterwards.
